pipe_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the stall, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also produces the EX-stage forwarding selects and freezes the pipeline while a multi-cycle data-memory access completes. It sits beside the datapath and watches destination and source register fields from ID, EX, MEM and WB.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding-select codes and the hardwired zero register.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM wins over WB because it holds the younger result; r0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] mem_rw,
    input logic       mem_regwr,
    input logic [4:0] wb_rw,
    input logic       wb_regwr
  );
    if (mem_regwr && (mem_rw != REG_ZERO) && (mem_rw == src))
      return FWD_MEM;
    else if (wb_regwr && (wb_rw != REG_ZERO) && (wb_rw == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EX-stage forwarding selects for both ALU operands.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rw,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rw,
  input  logic       wb_regwr,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_select(ex_rs, mem_rw, mem_regwr, wb_rw, wb_regwr);
  assign fwd_b = fwd_select(ex_rt, mem_rw, mem_regwr, wb_rw, wb_regwr);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: memory freeze, branch
// flush, load-use stall and forwarding. PIPE_PERF_CNT_EN builds the stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwr,
  input  logic             ex_memtoreg,
  input  logic             branch_taken,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regwr,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rw,
  input  logic             wb_regwr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             err_reg, err_next;
  logic             freeze;
  logic             load_use;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    freeze        = 1'b0;
    unique case (state_reg)
      ST_RUN:      freeze = dmem_req && !dmem_ready;
      ST_MEM_WAIT: freeze = !dmem_ready;
      default:     freeze = 1'b0;
    endcase
    if (freeze) begin
      // The last waited cycle still freezes; the stuck access is then dropped.
      if (wait_cnt_reg == WAIT_LAST) begin
        err_next      = 1'b1;
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end else begin
        state_next    = ST_MEM_WAIT;
        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
      end
    end else begin
      state_next    = ST_RUN;
      wait_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign mem_timeout_err = err_reg;

  assign load_use = ex_memtoreg && ex_regwr && (ex_rw != REG_ZERO) &&
                    ((ex_rw == id_rs) || (id_uses_rt && (ex_rw == id_rt)));

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  fwd_unit u_fwd (
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .mem_rw    (mem_rw),
    .mem_regwr (mem_regwr),
    .wb_rw     (wb_rw),
    .wb_regwr  (wb_regwr),
    .fwd_a     (fwd_a_raw),
    .fwd_b     (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pc_stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (ifid_flush && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
